// File: rtl/alu_serial.sv
`default_nettype none
// ============================================================================
// alu_serial : bit-serial WIDTH-bit ALU (ADD/SUB/AND/OR/NOR/XOR), LSB first
// Rev 1.0
// ============================================================================
module alu_serial #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       control,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_NOR = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [2:0]       op;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             slice_out;
  logic             slice_cout;
  logic             b_eff;
  logic             is_arith;
  logic [WIDTH-1:0] res_word;

  // One-bit ALU slice fed from the LSB of the operand shift registers.
  always_comb begin
    is_arith   = (op == OP_ADD) || (op == OP_SUB);
    b_eff      = b_sh[0] ^ (op == OP_SUB);
    slice_out  = 1'b0;
    slice_cout = carry;
    case (op)
      OP_ADD, OP_SUB: begin
        slice_out  = a_sh[0] ^ b_eff ^ carry;
        slice_cout = (a_sh[0] & b_eff) | (a_sh[0] & carry) | (b_eff & carry);
      end
      OP_AND:  slice_out = a_sh[0] & b_sh[0];
      OP_OR:   slice_out = a_sh[0] | b_sh[0];
      OP_NOR:  slice_out = ~(a_sh[0] | b_sh[0]);
      OP_XOR:  slice_out = a_sh[0] ^ b_sh[0];
      default: slice_out = 1'b0;
    endcase
    res_word = {slice_out, res_sh[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      out      <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      op       <= 3'd0;
      carry    <= 1'b0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_word;
          carry  <= slice_cout;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            // Result and flags land together with the done pulse; the carry
            // register still holds the carry into the MSB slice here.
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            out      <= res_word;
            carryout <= is_arith & slice_cout;
            overflow <= is_arith & (carry ^ slice_cout);
            zero     <= (res_word == '0);
            negative <= res_word[WIDTH-1];
          end
        end
        default: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            a_sh  <= A;
            b_sh  <= B;
            op    <= control;
            cnt   <= '0;
            carry <= (control == OP_SUB);
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_serial.sv
`default_nettype none
// Self-checking bench for alu_serial: directed table, handshake sequences,
// and randomized operations against an arithmetic reference model.
module tb_alu_serial;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [2:0]   control = 3'd0;
  logic         busy, done, carryout, overflow, zero, negative;
  logic [W-1:0] out;

  int tests = 0;
  int fails = 0;

  alu_serial #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .control(control),
    .busy(busy), .done(done), .out(out), .carryout(carryout),
    .overflow(overflow), .zero(zero), .negative(negative)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] e_out;
    logic         e_c;
    logic         e_v;
    logic         e_z;
    logic         e_n;
  } vec_t;

  typedef struct {
    logic [W-1:0] o;
    logic         c;
    logic         v;
    logic         z;
    logic         n;
  } res_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference: whole-word arithmetic with a W+1 bit sum.
  function automatic res_t model(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    logic [W:0] s;
    r.o = '0; r.c = 1'b0; r.v = 1'b0;
    case (c)
      3'd2: begin
        s = {1'b0, a} + {1'b0, b};
        r.o = s[W-1:0]; r.c = s[W];
        r.v = (a[W-1] == b[W-1]) && (r.o[W-1] != a[W-1]);
      end
      3'd3: begin
        s = {1'b0, a} + {1'b0, ~b} + 1;
        r.o = s[W-1:0]; r.c = s[W];
        r.v = (a[W-1] != b[W-1]) && (r.o[W-1] != a[W-1]);
      end
      3'd4: r.o = a & b;
      3'd5: r.o = a | b;
      3'd6: r.o = ~(a | b);
      3'd7: r.o = a ^ b;
      default: r.o = '0;
    endcase
    r.z = (r.o == '0);
    r.n = r.o[W-1];
    return r;
  endfunction

  task automatic chk_res(input string tag, input res_t e);
    chk({tag, ".out"}, out, e.o);
    chk({tag, ".carryout"}, carryout, e.c);
    chk({tag, ".overflow"}, overflow, e.v);
    chk({tag, ".zero"}, zero, e.z);
    chk({tag, ".negative"}, negative, e.n);
  endtask

  // Wait (bounded) until done is seen; returns cycles counted after the accept edge.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] c, input logic [W-1:0] a,
                        input logic [W-1:0] b, input res_t e);
    int lat;
    @(negedge clk);
    control = c; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = ~a; B = ~b; control = ~c;
    chk({tag, ".busy_up"}, busy, 1'b1);
    wait_done(lat);
    chk({tag, ".latency"}, lat, W);
    chk({tag, ".busy_at_done"}, busy, 1'b0);
    chk_res(tag, e);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, done, 1'b0);
  endtask

  vec_t vecs[$];
  res_t e;
  int   lat;
  bit   saw;

  initial begin
    vecs.push_back('{3'd2, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{3'd3, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{3'd3, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{3'd3, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{3'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{3'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'd7, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0});

    // Reset and idle
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", busy, 1'b0);
    chk("rst.done", done, 1'b0);
    chk("rst.out", out, '0);
    chk("rst.flags", {carryout, overflow, zero, negative}, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    saw = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (busy || done) saw = 1'b1;
    end
    chk("idle.no_activity", saw, 1'b0);
    chk("idle.out", out, '0);

    // Directed table
    for (int i = 0; i < vecs.size(); i++) begin
      e.o = vecs[i].e_out; e.c = vecs[i].e_c; e.v = vecs[i].e_v;
      e.z = vecs[i].e_z;   e.n = vecs[i].e_n;
      run_op($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].a, vecs[i].b, e);
    end

    // start during RUN is ignored
    @(negedge clk);
    control = 3'd2; A = 32'd100; B = 32'd23; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    control = 3'd3; A = 32'hDEAD_BEEF; B = 32'h1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 5;
    while (!done && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("ignore.latency", lat, W);
    chk_res("ignore", model(3'd2, 32'd100, 32'd23));

    // Back-to-back with start held high through done
    @(negedge clk);
    control = 3'd2; A = 32'h0000_0010; B = 32'h0000_0020; start = 1'b1;
    @(posedge clk); #1;
    control = 3'd3; A = 32'h0000_0003; B = 32'h0000_0007;
    wait_done(lat);
    chk("b2b.first_latency", lat, W);
    chk_res("b2b.first", model(3'd2, 32'h10, 32'h20));
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b.busy_again", busy, 1'b1);
    chk("b2b.done_low", done, 1'b0);
    lat = 1;
    while (!done && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("b2b.spacing", lat, W + 1);
    chk_res("b2b.second", model(3'd3, 32'h3, 32'h7));

    // Reset during RUN aborts without done
    @(negedge clk);
    control = 3'd2; A = 32'h1111_1111; B = 32'h2222_2222; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    @(negedge clk);
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    chk("abort.busy", busy, 1'b0);
    chk("abort.done", done, 1'b0);
    chk("abort.out", out, '0);
    chk("abort.flags", {carryout, overflow, zero, negative}, 4'b0000);
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) saw = 1'b1;
    end
    chk("abort.no_done", saw, 1'b0);
    run_op("after_abort", 3'd2, 32'h1111_1111, 32'h2222_2222, model(3'd2, 32'h1111_1111, 32'h2222_2222));

    // Randomized operations
    for (int k = 0; k < 150; k++) begin
      logic [2:0]   rc;
      logic [W-1:0] ra, rb;
      rc = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (k % 8 == 0) ? ra : $urandom;
      run_op($sformatf("rnd%0d", k), rc, ra, rb, model(rc, ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_serial.md
# alu_serial

Bit-serial WIDTH-bit ALU. It owns the opposite side of the 1-bit ALU slice interface: it feeds one operand bit pair plus carry per cycle into an internal slice and collects the slice's out/carryout bits into a word result with flags. It sits beside the combinational word ALU as a low-area alternative, using a start/busy/done handshake toward the datapath controller.

## Interface
- WIDTH, 32, operand/result width in bits (≥2).
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; aborts any operation.
- start  input  1  request; sampled only when not busy.
- A  input  WIDTH  operand A; latched on accepted start.
- B  input  WIDTH  operand B; latched on accepted start.
- control  input  3  op: 2=ADD, 3=SUB, 4=AND, 5=OR, 6=NOR, 7=XOR; 0/1 reserved.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; result and flags valid from this cycle.
- out  output  WIDTH  result; holds until the next completion.
- carryout  output  1  carry out of the MSB slice (ADD/SUB); 0 for logic ops.
- overflow  output  1  signed overflow (ADD/SUB); 0 for logic ops.
- zero  output  1  out == 0.
- negative  output  1  out[WIDTH-1].

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 latches A, B, control; clears the bit counter; loads carry = 1 for SUB, else 0; goes to RUN.
- RUN: each cycle processes bit i (LSB first, i = counter).
  - ADD: sum = a^b^c, c' = majority(a,b,c).
  - SUB: same with b inverted (two's complement via initial carry = 1).
  - AND/OR/NOR/XOR: bitwise result; carry is unchanged.
  - Reserved ops: result bit 0.
  - The result bit shifts into an internal shift register from the MSB side.
  - Counter increments. At i = WIDTH-1, record carry-in to the MSB (c_msb_in) and go to DONE.
- DONE: out ← shift register; carryout ← final carry (ADD/SUB), else 0; overflow ← c_msb_in ^ final carry (ADD/SUB), else 0; zero and negative are computed from the new out; done=1. Next state is IDLE, or RUN if start=1 (back-to-back, new operands latched).
- out and flags are registered. They change only on the DONE transition and on reset.
- Carry semantics: SUB carryout=1 means no borrow (A ≥ B unsigned).
- start while in RUN is ignored; the operation is not queued.
- Operand/control changes after acceptance have no effect.

## Timing
- Reset values: busy=0, done=0, out=0, carryout=0, overflow=0, zero=0, negative=0; state IDLE; counter 0.
- Start accepted at edge E0 → busy=1 after E0. Bits 0..WIDTH-1 are processed at edges E1..E(WIDTH).
- After E(WIDTH): done=1 and busy=0, with out/flags updated in the same cycle. Latency is WIDTH cycles from the accepting edge to the done cycle.
- done is high for exactly one cycle unless another operation completes.
- busy is high for exactly WIDTH cycles per operation.
- Back-to-back: start=1 during the done cycle is accepted at that edge, so busy rises again the next cycle. Maximum throughput is one result per WIDTH+1 cycles.
- Reset mid-RUN: at the next edge, state returns to IDLE and all outputs take their reset values. No done is issued for the aborted operation.
- Reset and start asserted together: reset wins and start is dropped.
- Counter wrap: the counter is ceil(log2(WIDTH)) bits wide and never wraps inside RUN. RUN exits on counter == WIDTH-1.

## Test plan
- Reset/idle: hold reset 2 cycles, then idle 5 cycles with start=0 → all outputs 0, busy never rises.
- ADD 0x7FFFFFFF + 0x00000001 (WIDTH=32) → after exactly 32 cycles: done=1, out=0x80000000, overflow=1, negative=1, carryout=0, zero=0.
- SUB 5 − 5 → out=0, zero=1, carryout=1, overflow=0. SUB 0 − 1 → out=0xFFFFFFFF, carryout=0, negative=1.
- Logic ops on A=0xF0F0F0F0, B=0xFF00FF00 → AND 0xF000F000, OR 0xFFF0FFF0, NOR 0x000F000F, XOR 0x0FF00FF0. Each case: carryout=0, overflow=0.
- Handshake: start pulsed at cycle 5 of RUN with different operands → ignored, result matches the first op. start held high through done → second op accepted with no idle cycle, second done exactly 33 cycles after the first.
- Reset at RUN cycle 10 of an ADD → next cycle busy=0, out=0, all flags 0. No done pulse. A subsequent start runs normally.
